// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default widths and gray/binary pointer conversion.
// Pointer helpers work on a 32-bit container; callers zero-extend and truncate to their width.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_OVF_CNT_W  = 8;
  localparam int PTR_MAX_W      = 32;

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic W-bit, N-stage flop synchronizer with asynchronous active-high reset.
// Stages are plain flop-to-flop; the input must come straight from a register in the source domain.
module sync_chain
  import fifo_pkg::*;
#(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_d [N];
  logic [W-1:0] stage_q [N];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < N; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[N-1];

endmodule

// File: rtl/wr_rptr_sync.sv
// Write-side receiver of the gray read pointer: sync, registered level, almost-full, overflow count.
// WR_SYNC_3STAGE_EN selects a 3-flop synchronizer instead of the default 2-flop one.
module wr_rptr_sync
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int OVF_CNT_W  = DEF_OVF_CNT_W
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   rd_gray_ptr,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  wr_en,
  input  logic                  wr_full,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH:0]   sync_read_ptr,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_almost_full,
  output logic [OVF_CNT_W-1:0]  ovf_count
);

  localparam int PW = ADDR_WIDTH + 1;

`ifdef WR_SYNC_3STAGE_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  logic [PW-1:0]        sync_ptr;
  logic [PW-1:0]        rd_bin;
  logic [PW-1:0]        wr_bin;
  logic [PW-1:0]        wr_level_d, wr_level_q;
  logic                 wr_af_d, wr_af_q;
  logic [OVF_CNT_W-1:0] ovf_cnt_d, ovf_cnt_q;

  sync_chain #(
    .W (PW),
    .N (SYNC_N)
  ) u_rptr_sync (
    .clk   (wr_clk),
    .reset (reset),
    .d     (rd_gray_ptr),
    .q     (sync_ptr)
  );

  // A stale synced read pointer lags the real one, so this difference can only overstate occupancy.
  always_comb begin
    rd_bin     = PW'(gray2bin(PTR_MAX_W'(sync_ptr)));
    wr_bin     = PW'(gray2bin(PTR_MAX_W'(wr_ptr)));
    wr_level_d = wr_bin - rd_bin;
    wr_af_d    = (af_thresh != '0) && (wr_level_d >= af_thresh);

    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (wr_en && wr_full && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      wr_level_q <= '0;
      wr_af_q    <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      wr_level_q <= wr_level_d;
      wr_af_q    <= wr_af_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign sync_read_ptr  = sync_ptr;
  assign wr_level       = wr_level_q;
  assign wr_almost_full = wr_af_q;
  assign ovf_count      = ovf_cnt_q;

endmodule

// File: tb/tb_wr_rptr_sync.sv
// Scoreboarded bench for wr_rptr_sync: directed corner cases plus a randomized two-clock FIFO run.
module tb_wr_rptr_sync;

`ifdef WR_SYNC_3STAGE_EN
  localparam int NS = 3;
`else
  localparam int NS = 2;
`endif

  logic       wr_clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] rd_gray_ptr = '0;
  logic [5:0] wr_ptr = '0;
  logic       wr_en = 1'b0;
  logic       wr_full = 1'b0;
  logic [5:0] af_thresh = '0;
  logic       ovf_clr = 1'b0;
  logic [5:0] sync_read_ptr;
  logic [5:0] wr_level;
  logic       wr_almost_full;
  logic [7:0] ovf_count;

  wr_rptr_sync #(.ADDR_WIDTH(5), .OVF_CNT_W(8)) dut (
    .wr_clk         (wr_clk),
    .reset          (reset),
    .rd_gray_ptr    (rd_gray_ptr),
    .wr_ptr         (wr_ptr),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .af_thresh      (af_thresh),
    .ovf_clr        (ovf_clr),
    .sync_read_ptr  (sync_read_ptr),
    .wr_level       (wr_level),
    .wr_almost_full (wr_almost_full),
    .ovf_count      (ovf_count)
  );

  always #50 wr_clk = ~wr_clk;

  typedef struct {
    logic [5:0] sync;
    int         level;
    bit         af;
    int         ovf;
    bit         chk_occ;
    int         wr_abs;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] rd_hist[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         ovf_m = 0;
  int         model_sync_bin = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  bit         fifo_mode = 1'b0;

  function automatic int g2b(input logic [5:0] g);
    for (int i = 0; i < 64; i++) begin
      if (6'(i ^ (i >> 1)) == g) return i;
    end
    return -1;
  endfunction

  function automatic logic [5:0] b2g(input int b);
    return 6'((b ^ (b >> 1)) & 63);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference: each edge pushes what the outputs must show afterwards.
  always @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      sb_q.delete();
      rd_hist.delete();
      for (int i = 0; i <= NS; i++) rd_hist.push_back(6'd0);
      ovf_m = 0;
      model_sync_bin = 0;
    end else begin
      exp_t       e;
      logic [5:0] s_before;
      rd_hist.push_back(rd_gray_ptr);
      s_before  = rd_hist[rd_hist.size() - 1 - NS];
      e.sync    = rd_hist[rd_hist.size() - NS];
      e.level   = (g2b(wr_ptr) - g2b(s_before) + 64) % 64;
      e.af      = (af_thresh != 0) && (e.level >= int'(af_thresh));
      if (ovf_clr) ovf_m = 0;
      else if (wr_en && wr_full && ovf_m < 255) ovf_m++;
      e.ovf     = ovf_m;
      e.chk_occ = fifo_mode;
      e.wr_abs  = wr_cnt;
      model_sync_bin = g2b(e.sync);
      sb_q.push_back(e);
      void'(rd_hist.pop_front());
    end
  end

  logic [5:0] prev_sync = '0;

  always @(negedge wr_clk) begin
    if (reset) begin
      prev_sync = '0;
    end else if (sb_q.size() > 0) begin
      exp_t e;
      int   occ;
      e = sb_q.pop_front();
      check("sync_read_ptr", 32'(sync_read_ptr), 32'(e.sync));
      check("wr_level", 32'(wr_level), e.level);
      check("wr_almost_full", 32'(wr_almost_full), 32'(e.af));
      check("ovf_count", 32'(ovf_count), e.ovf);
      if (e.chk_occ) begin
        occ = e.wr_abs - rd_cnt;
        check("level_ge_true_occ", 32'(int'(wr_level) >= occ), 1);
        check("level_le_depth", 32'(wr_level <= 6'd32), 1);
        check("sync_one_bit_step", 32'($countones(sync_read_ptr ^ prev_sync) <= 1), 1);
      end
      prev_sync = sync_read_ptr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  // Called one time unit after a rising edge; returns at the same phase with reset released.
  task automatic do_reset(input string nm);
    #29;
    reset       = 1'b1;
    rd_gray_ptr = 6'($urandom);
    wr_ptr      = 6'($urandom);
    af_thresh   = 6'($urandom);
    wr_en       = 1'($urandom);
    wr_full     = 1'($urandom);
    ovf_clr     = 1'($urandom);
    #1;
    check({nm, "_sync"}, 32'(sync_read_ptr), 0);
    check({nm, "_level"}, 32'(wr_level), 0);
    check({nm, "_af"}, 32'(wr_almost_full), 0);
    check({nm, "_ovf"}, 32'(ovf_count), 0);
    rd_gray_ptr = '0;
    wr_ptr      = '0;
    af_thresh   = '0;
    wr_en       = 1'b0;
    wr_full     = 1'b0;
    ovf_clr     = 1'b0;
    wr_cnt      = 0;
    rd_cnt      = 0;
    fifo_mode   = 1'b0;
    @(negedge wr_clk);
    #20;
    reset = 1'b0;
    @(posedge wr_clk);
    #1;
  endtask

  // Read side steps on a ~268-unit clock unrelated to the 100-unit write clock.
  task automatic run_random(input int cycles);
    int rd_ticks;
    rd_ticks  = (cycles * 10) / 27;
    fifo_mode = 1'b1;
    fork
      begin
        for (int c = 0; c < cycles; c++) begin
          wr_en   = 1'($urandom_range(0, 1));
          wr_full = ($urandom_range(0, 3) == 0);
          ovf_clr = ($urandom_range(0, 31) == 0);
          if ($urandom_range(0, 15) == 0) af_thresh = 6'($urandom_range(0, 40));
          if ($urandom_range(0, 1) == 1 &&
              ((((wr_cnt + 1) % 64) - model_sync_bin + 64) % 64) <= 32) begin
            wr_cnt = wr_cnt + 1;
            wr_ptr = b2g(wr_cnt % 64);
          end
          @(posedge wr_clk);
          #1;
        end
      end
      begin
        #2;
        for (int r = 0; r < rd_ticks; r++) begin
          if ($urandom_range(0, 3) != 0 && rd_cnt < wr_cnt) begin
            rd_cnt      = rd_cnt + 1;
            rd_gray_ptr = b2g(rd_cnt % 64);
          end
          #268;
        end
      end
    join
    fifo_mode = 1'b0;
  endtask

  initial begin
    do_reset("reset_init");

    wr_ptr    = 6'h1E;
    af_thresh = 6'd20;
    tick(1);
    check("lvl20", 32'(wr_level), 20);
    check("af_at_thresh", 32'(wr_almost_full), 1);
    af_thresh = 6'd21;
    tick(1);
    check("af_below_thresh", 32'(wr_almost_full), 0);

    wr_ptr = 6'h30;
    tick(1);
    check("lvl_full", 32'(wr_level), 32);
    wr_ptr      = 6'h02;
    rd_gray_ptr = 6'h22;
    tick(NS + 1);
    check("lvl_wrap", 32'(wr_level), 7);

    rd_gray_ptr = '0;
    wr_ptr      = 6'h30;
    af_thresh   = 6'd33;
    tick(NS + 2);
    check("af_thresh_over_depth", 32'(wr_almost_full), 0);
    af_thresh = 6'd32;
    tick(1);
    check("af_thresh_depth", 32'(wr_almost_full), 1);
    af_thresh = 6'd0;
    tick(1);
    check("af_disabled", 32'(wr_almost_full), 0);

    wr_ptr = 6'h1E;
    tick(NS + 2);
    check("lvl_steady", 32'(wr_level), 20);
    rd_gray_ptr = 6'h07;
    for (int k = 1; k <= NS + 1; k++) begin
      tick(1);
      check("lat_sync", 32'(sync_read_ptr), (k >= NS) ? 32'd7 : 32'd0);
      check("lat_level", 32'(wr_level), (k >= NS + 1) ? 32'd15 : 32'd20);
    end

    wr_en   = 1'b1;
    wr_full = 1'b1;
    tick(300);
    check("ovf_saturate", 32'(ovf_count), 255);
    ovf_clr = 1'b1;
    tick(1);
    check("ovf_clr_wins", 32'(ovf_count), 0);
    ovf_clr = 1'b0;
    tick(1);
    check("ovf_restart", 32'(ovf_count), 1);
    wr_en   = 1'b0;
    wr_full = 1'b0;
    tick(1);

    do_reset("reset_pre_random");
    run_random(1500);
    do_reset("reset_mid_run");
    run_random(1500);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
